// File: rtl/seg7_scan_driver.sv
// Scans four BCD digits onto a multiplexed 7-segment display, with per-slot blanking, a per-frame snapshot and a blinking colon.
// an/seg/dp are registered one cycle behind slot_cnt/idx; the block is free-running and has no backpressure.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit COMMON_ANODE = 1'b1,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic       ptflag,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} slot_state_t;

  logic [CW-1:0]   slot_cnt;
  logic [1:0]      idx;
  logic            cnt_last;
  logic            primed;
  logic            snap_load;
  logic [3:0][3:0] snap_d;
  logic            snap_pt;
  slot_state_t     state;
  logic [3:0]      cur_digit;
  logic [3:0]      an_act;
  logic [6:0]      seg_act;
  logic            dp_act;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  assign cnt_last  = (slot_cnt == CNT_LAST);
  // First edge after reset, then the edge that enters slot 0 of the next frame.
  assign snap_load = !primed || ((idx == 2'd3) && cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (cnt_last) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed      <= 1'b0;
      snap_d      <= '0;
      snap_pt     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      primed      <= 1'b1;
      frame_start <= snap_load;
      if (snap_load) begin
        snap_d  <= {digit4, digit3, digit2, digit1};
        snap_pt <= ptflag;
      end
    end
  end

  assign state     = (slot_cnt < BLANK_END) ? ST_BLANK : ST_SHOW;
  assign cur_digit = snap_d[idx];

  always_comb begin
    an_act  = '0;
    seg_act = '0;
    dp_act  = 1'b0;
    case (state)
      ST_SHOW: begin
        an_act  = 4'b1000 >> idx;
        seg_act = (LZ_BLANK && (idx == 2'd0) && (cur_digit == 4'd0)) ? 7'd0 : decode(cur_digit);
        dp_act  = (idx == 2'd1) && snap_pt;
      end
      default: ;
    endcase
  end

  // XOR with the polarity mask gives active-low pins for common-anode boards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= {4{COMMON_ANODE}};
      seg <= {7{COMMON_ANODE}};
      dp  <= COMMON_ANODE;
    end else begin
      an  <= an_act ^ {4{COMMON_ANODE}};
      seg <= seg_act ^ {7{COMMON_ANODE}};
      dp  <= dp_act ^ COMMON_ANODE;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver over three parameter sets sharing one stimulus stream.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  localparam int NI = 3;
  localparam int SD [NI] = '{8, 8, 5};
  localparam int BC [NI] = '{2, 2, 0};
  localparam bit CA [NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit LZ [NI] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d1, d2, d3, d4;
  logic       pt;
  logic [6:0] seg [NI];
  logic       dp  [NI];
  logic [3:0] an  [NI];
  logic       fs  [NI];

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  logic [3:0] snap [NI][4];
  logic       spt  [NI];
  exp_t [NI-1:0] exp_q [$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4), .ptflag(pt),
    .seg(seg[0]), .dp(dp[0]), .an(an[0]), .frame_start(fs[0]));
  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(1'b0), .LZ_BLANK(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4), .ptflag(pt),
    .seg(seg[1]), .dp(dp[1]), .an(an[1]), .frame_start(fs[1]));
  seg7_scan_driver #(.SCAN_DIV(5), .BLANK_CYCLES(0), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4), .ptflag(pt),
    .seg(seg[2]), .dp(dp[2]), .an(an[2]), .frame_start(fs[2]));

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: glyph = 7'b0111111;  4'd1: glyph = 7'b0000110;
      4'd2: glyph = 7'b1011011;  4'd3: glyph = 7'b1001111;
      4'd4: glyph = 7'b1100110;  4'd5: glyph = 7'b1101101;
      4'd6: glyph = 7'b1111101;  4'd7: glyph = 7'b0000111;
      4'd8: glyph = 7'b1111111;  4'd9: glyph = 7'b1101111;
      default: glyph = 7'b1000000;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NI; k++) begin
      spt[k] = 1'b0;
      for (int i = 0; i < 4; i++) snap[k][i] = 4'd0;
    end
  endtask

  // One rising edge with reset released: edge n shows position n-1 of the free-running scan.
  task automatic model_edge();
    exp_t [NI-1:0] ex;
    logic [3:0] left;
    int p, cnt, ix;
    bit show, load;
    n++;
    p = n - 1;
    left = 4'b1000;
    for (int k = 0; k < NI; k++) begin
      cnt  = p % SD[k];
      ix   = (p / SD[k]) % 4;
      show = (cnt >= BC[k]);
      load = (n == 1) || ((p % (4 * SD[k])) == 4 * SD[k] - 1);
      ex[k].an  = show ? (left >> ix) : 4'd0;
      ex[k].seg = 7'd0;
      if (show && !(LZ[k] && ix == 0 && snap[k][0] == 4'd0)) ex[k].seg = glyph(snap[k][ix]);
      ex[k].dp  = show && ix == 1 && spt[k];
      ex[k].fs  = load;
      if (CA[k]) begin
        ex[k].an  = ~ex[k].an;
        ex[k].seg = ~ex[k].seg;
        ex[k].dp  = ~ex[k].dp;
      end
      if (load) begin
        snap[k][0] = d1; snap[k][1] = d2; snap[k][2] = d3; snap[k][3] = d4;
        spt[k] = pt;
      end
    end
    exp_q.push_back(ex);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic check_inactive(input string name);
    exp_t want;
    for (int k = 0; k < NI; k++) begin
      want.an  = {4{CA[k]}};
      want.seg = {7{CA[k]}};
      want.dp  = CA[k];
      want.fs  = 1'b0;
      vectors++;
      if ({an[k], seg[k], dp[k], fs[k]} !== want) begin
        miscompares++;
        $display("FAIL %s inst%0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                 name, k, an[k], seg[k], dp[k], fs[k], want.an, want.seg, want.dp, want.fs);
      end
    end
  endtask

  // Monitor: every cycle after reset release the DUTs present a value to check.
  always @(negedge clk) begin
    exp_t [NI-1:0] ex;
    logic [3:0] an_hi;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if ({an[k], seg[k], dp[k], fs[k]} !== ex[k]) begin
          miscompares++;
          $display("FAIL scan inst%0d edge%0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                   k, n, an[k], seg[k], dp[k], fs[k], ex[k].an, ex[k].seg, ex[k].dp, ex[k].fs);
        end
        an_hi = CA[k] ? ~an[k] : an[k];
        vectors++;
        if ($countones(an_hi) > 1) begin
          miscompares++;
          $display("FAIL onehot inst%0d: got active anodes=%b, want at most one", k, an_hi);
        end
      end
    end
  end

  initial begin
    d1 = 4'd2; d2 = 4'd3; d3 = 4'd5; d4 = 4'd9; pt = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_inactive("reset_hold");
    rst_n = 1'b1;
    run(96);

    // Change digit4 while slot 1 of instance a is on screen; the snapshot must hide it until next frame.
    while (((n / 8) % 4) != 1) step();
    d4 = 4'd4;
    run(64);

    d1 = 4'd0; d2 = 4'd7; d3 = 4'd0; d4 = 4'd0; pt = 1'b0;
    run(64);
    pt = 1'b1;
    run(64);
    d3 = 4'hC;
    run(64);

    // Asynchronous reset in the middle of a SHOW phase.
    while (((n - 1) % 8) != 4) step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_inactive("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_inactive("reset_hold2");
    rst_n = 1'b1;

    repeat (2000) begin
      step();
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: d1 = 4'($urandom_range(0, 15));
          1: d2 = 4'($urandom_range(0, 15));
          2: d3 = 4'($urandom_range(0, 15));
          3: d4 = 4'($urandom_range(0, 15));
          default: pt = ~pt;
        endcase
      end
    end

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the hours/minutes clock counter.
- Takes four BCD digits plus the half-second blink flag.
- Time-multiplexes them onto a 4-digit seven-segment display, with per-slot ghost blanking, a frame-coherent input snapshot, leading-zero blanking and a blinking colon on the decimal point of digit 2.
- Sits between the clock counter and the board pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (50 MHz gives 1 kHz per slot, 250 Hz per frame); must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < SCAN_DIV.
- COMMON_ANODE, 1: 1 = seg/dp/an active-low; 0 = active-high.
- LZ_BLANK, 1: 1 = blank digit1 when it is 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- digit1  input  4  hours tens (BCD)
- digit2  input  4  hours units
- digit3  input  4  minutes tens
- digit4  input  4  minutes units
- ptflag  input  1  blink flag; 1 = colon lit
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per COMMON_ANODE
- dp  output  1  decimal point, polarity per COMMON_ANODE
- an  output  4  digit enables; an[3] = digit1 (leftmost) … an[0] = digit4
- frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (rst_n low, asynchronous):
  - slot_cnt=0, idx=0, all snapshot registers 0, primed=0, frame_start=0.
  - an, seg and dp are all at the inactive level: all 1 if COMMON_ANODE=1, all 0 if COMMON_ANODE=0.
  - Reset mid-frame aborts the scan immediately; outputs go inactive in the same cycle.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, idx increments mod 4: 0→1→2→3→0.
  - idx 0..3 selects digit1..digit4.
- Snapshot:
  - Loads digit1..4 and ptflag on the first rising edge after reset release (primed goes 0→1).
  - Thereafter loads on every edge where idx==3 and slot_cnt==SCAN_DIV-1, i.e. entering slot 0.
  - frame_start is registered and high exactly in the cycle after each load.
  - Input changes mid-frame are never displayed until the next snapshot; no tearing.
- Slot state machine, evaluated from the current slot_cnt/idx:
  - BLANK while slot_cnt < BLANK_CYCLES: all anodes inactive; seg and dp inactive.
  - SHOW otherwise: only the anode for idx is active.
    - seg = decode(snapshot digit).
    - dp active only when idx==1 and snapshot ptflag==1.
- Decode, active-level bits g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 = 1000000 (dash).
- Leading-zero blanking: when LZ_BLANK=1, idx==0 and snapshot digit1==0, seg is all inactive. The anode is still active; dp is unaffected.
- Latency: an/seg/dp are registered. Port values in cycle t+1 reflect the slot_cnt/idx of cycle t, so there is one cycle of latency from the counters to the pins.
- Polarity: when COMMON_ANODE=1, the final an/seg/dp are the bitwise inverse of the active-high internal values.
- Never more than one anode active in any cycle, including across slot boundaries.
- Widths:
  - slot_cnt is $clog2(SCAN_DIV) bits.
  - The slot_cnt==SCAN_DIV-1 comparison must be width-safe for non-power-of-2 values.
- BLANK_CYCLES=0: the SHOW state occupies the whole slot. An anode change at a slot boundary is then a direct switch, with no all-off gap.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, COMMON_ANODE=1, LZ_BLANK=1 unless stated):
1. Reset: hold rst_n=0 with digits=2,3,5,9 → an=1111, seg=1111111, dp=1, frame_start=0; assert rst_n low mid-SHOW → outputs go inactive without waiting for a clk edge.
2. Basic scan: digits=2,3,5,9, ptflag=1, release reset.
   - frame_start pulses once.
   - Each 8-cycle slot shows 2 cycles of an=1111, then 6 cycles of the active digit: an=0111 with seg=~1011011, an=1011 with seg=~1001111 and dp=0, an=1101 with seg=~1101101, an=1110 with seg=~1101111.
   - Frame period is 32 cycles.
3. Snapshot coherence: change digit4 from 9 to 4 while idx==1 → slot 3 of the current frame still shows 9; the next frame shows 4, following a frame_start pulse.
4. Blink and leading zero:
   - digits=0,7,0,0, ptflag=0 → slot 0 has anode active with all segments off; slot 1 shows 7 with dp=1 (off).
   - Set ptflag=1 → dp=0 in slot 1 starting from the next frame.
   - Rerun with LZ_BLANK=0 → slot 0 shows 0.
5. Invalid code and polarity: digit3=4'hC, COMMON_ANODE=0 → slot 2 shows an=0100 and seg=1000000. Across a full frame, at most one an bit is high in any cycle.
6. Edge params: BLANK_CYCLES=0 with SCAN_DIV=5 → there is no blank gap; idx wraps correctly after 20 cycles; frame_start fires every 20 cycles.
